lockin_accumulator: RTL and testbench

- Dual-phase lock-in core; sits directly upstream of the control/Qsys block.
- Multiplies each ADC sample by in-phase and quadrature reference samples and accumulates the products over M periods of N samples.
- Delivers 64-bit X/Y results with a valid pulse into the 64-bit result FIFOs and raises calculo_finalizado.
- Runs on clk_custom; is gated by enable and cleared by reset_from_control.

---
 rtl/lockin_accumulator_if.sv | 43 ++++
 rtl/lockin_accumulator.sv | 271 +++++++++++++++++++++++++++
 tb/tb_lockin_accumulator.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lockin_accumulator_if.sv
`default_nettype none
// ============================================================================
// lockin_accumulator_if : sample/reference stream in, X/Y result out.
// Optional LOCKIN_RESULT32_EN adds the 32-bit result signals. Revision: 1.0
// ============================================================================
interface lockin_accumulator_if #(
  parameter int DATA_W = 14,
  parameter int REF_W  = 16
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_data;
  logic signed [REF_W-1:0]  ref_sin;
  logic signed [REF_W-1:0]  ref_cos;
  logic signed [63:0]       result_x;
  logic signed [63:0]       result_y;
  logic                     result_valid;
`ifdef LOCKIN_RESULT32_EN
  logic signed [31:0]       result_x_32;
  logic signed [31:0]       result_y_32;
  logic                     result_32_valid;

  modport master (
    output sample_valid, sample_data, ref_sin, ref_cos,
    input  result_x, result_y, result_valid,
    input  result_x_32, result_y_32, result_32_valid
  );
  modport slave (
    input  sample_valid, sample_data, ref_sin, ref_cos,
    output result_x, result_y, result_valid,
    output result_x_32, result_y_32, result_32_valid
  );
`else
  modport master (
    output sample_valid, sample_data, ref_sin, ref_cos,
    input  result_x, result_y, result_valid
  );
  modport slave (
    input  sample_valid, sample_data, ref_sin, ref_cos,
    output result_x, result_y, result_valid
  );
`endif
endinterface
`default_nettype wire

// File: rtl/lockin_accumulator.sv
`default_nettype none
// ============================================================================
// lockin_accumulator : dual-phase lock-in multiply/accumulate over M x N samples.
// Optional macro LOCKIN_RESULT32_EN adds shifted, saturated 32-bit results.
// Revision: 1.0
// ============================================================================
module lockin_accumulator #(
  parameter int DATA_W = 14,
  parameter int REF_W  = 16,
  parameter int CNT_W  = 16,
  parameter int SHIFT  = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             clear,
  input  wire logic             enable,
  input  wire logic [CNT_W-1:0] n_samples,
  input  wire logic [CNT_W-1:0] n_periods,
  lockin_accumulator_if.slave   bus,
  output logic                  calculo_finalizado,
  output logic [31:0]           samples_accepted
);

  localparam int PROD_W = DATA_W + REF_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         n_q, n_d, m_q, m_d;
  logic [CNT_W-1:0]         sample_idx_q, sample_idx_d;
  logic [CNT_W-1:0]         period_idx_q, period_idx_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
  logic signed [REF_W-1:0]  s1_sin_q, s1_sin_d, s1_cos_q, s1_cos_d;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [PROD_W-1:0] s2_px_q, s2_px_d, s2_py_q, s2_py_d;
  logic signed [63:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [63:0]       result_x_q, result_x_d, result_y_q, result_y_d;
  logic                     result_valid_q, result_valid_d;
  logic                     done_q, done_d;
  logic [31:0]              samples_q, samples_d;

  logic signed [PROD_W-1:0] data_ext, sin_ext, cos_ext, prod_x, prod_y;
  logic signed [63:0]       px_ext, py_ext;
  logic                     abort;

  // Operands are widened to the product width so the multiply is exact.
  assign data_ext = {{REF_W{s1_data_q[DATA_W-1]}}, s1_data_q};
  assign sin_ext  = {{DATA_W{s1_sin_q[REF_W-1]}}, s1_sin_q};
  assign cos_ext  = {{DATA_W{s1_cos_q[REF_W-1]}}, s1_cos_q};
  assign prod_x   = data_ext * sin_ext;
  assign prod_y   = data_ext * cos_ext;
  assign px_ext   = {{(64-PROD_W){s2_px_q[PROD_W-1]}}, s2_px_q};
  assign py_ext   = {{(64-PROD_W){s2_py_q[PROD_W-1]}}, s2_py_q};
  assign abort    = ((state_q == S_RUN) || (state_q == S_FLUSH)) && !enable;

`ifdef LOCKIN_RESULT32_EN
  logic signed [31:0] result_x_32_q, result_x_32_d, result_y_32_q, result_y_32_d;
  logic               result_32_valid_q, result_32_valid_d;

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    logic signed [63:0] s;
    s = v >>> SHIFT;
    if (s > 64'sh0000_0000_7FFF_FFFF)
      return 32'sh7FFF_FFFF;
    else if (s < -64'sh0000_0000_8000_0000)
      return 32'sh8000_0000;
    return s[31:0];
  endfunction

  assign bus.result_x_32     = result_x_32_q;
  assign bus.result_y_32     = result_y_32_q;
  assign bus.result_32_valid = result_32_valid_q;
`else
  logic unused_shift;
  assign unused_shift = (SHIFT != 0);
`endif

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    m_d            = m_q;
    sample_idx_d   = sample_idx_q;
    period_idx_d   = period_idx_q;
    s1_valid_d     = 1'b0;
    s1_data_d      = s1_data_q;
    s1_sin_d       = s1_sin_q;
    s1_cos_d       = s1_cos_q;
    s2_valid_d     = s1_valid_q;
    s2_px_d        = prod_x;
    s2_py_d        = prod_y;
    acc_x_d        = s2_valid_q ? acc_x_q + px_ext : acc_x_q;
    acc_y_d        = s2_valid_q ? acc_y_q + py_ext : acc_y_q;
    result_x_d     = result_x_q;
    result_y_d     = result_y_q;
    result_valid_d = 1'b0;
    done_d         = done_q;
    samples_d      = samples_q;
`ifdef LOCKIN_RESULT32_EN
    result_x_32_d     = result_x_32_q;
    result_y_32_d     = result_y_32_q;
    result_32_valid_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        acc_x_d      = '0;
        acc_y_d      = '0;
        sample_idx_d = '0;
        period_idx_d = '0;
        done_d       = 1'b0;
        if (enable && (n_samples != '0) && (n_periods != '0)) begin
          n_d       = n_samples;
          m_d       = n_periods;
          samples_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (enable && bus.sample_valid) begin
          s1_valid_d = 1'b1;
          s1_data_d  = bus.sample_data;
          s1_sin_d   = bus.ref_sin;
          s1_cos_d   = bus.ref_cos;
          samples_d  = samples_q + 32'd1;
          if (sample_idx_q == n_q - CNT_W'(1)) begin
            sample_idx_d = '0;
            period_idx_d = period_idx_q + CNT_W'(1);
            if (period_idx_q == m_q - CNT_W'(1))
              state_d = S_FLUSH;
          end else begin
            sample_idx_d = sample_idx_q + CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        // Both stages empty means the last product is already in the accumulators.
        if (!s1_valid_q && !s2_valid_q) begin
          result_x_d     = acc_x_q;
          result_y_d     = acc_y_q;
          result_valid_d = 1'b1;
          done_d         = 1'b1;
          state_d        = S_DONE;
`ifdef LOCKIN_RESULT32_EN
          result_x_32_d     = sat32(acc_x_q);
          result_y_32_d     = sat32(acc_y_q);
          result_32_valid_d = 1'b1;
`endif
        end
      end
      S_DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d        = S_IDLE;
      acc_x_d        = '0;
      acc_y_d        = '0;
      s1_valid_d     = 1'b0;
      s2_valid_d     = 1'b0;
      sample_idx_d   = '0;
      period_idx_d   = '0;
      result_x_d     = result_x_q;
      result_y_d     = result_y_q;
      result_valid_d = 1'b0;
      done_d         = 1'b0;
`ifdef LOCKIN_RESULT32_EN
      result_x_32_d     = result_x_32_q;
      result_y_32_d     = result_y_32_q;
      result_32_valid_d = 1'b0;
`endif
    end

    if (clear) begin
      state_d        = S_IDLE;
      n_d            = '0;
      m_d            = '0;
      sample_idx_d   = '0;
      period_idx_d   = '0;
      s1_valid_d     = 1'b0;
      s1_data_d      = '0;
      s1_sin_d       = '0;
      s1_cos_d       = '0;
      s2_valid_d     = 1'b0;
      s2_px_d        = '0;
      s2_py_d        = '0;
      acc_x_d        = '0;
      acc_y_d        = '0;
      result_x_d     = '0;
      result_y_d     = '0;
      result_valid_d = 1'b0;
      done_d         = 1'b0;
      samples_d      = '0;
`ifdef LOCKIN_RESULT32_EN
      result_x_32_d     = '0;
      result_y_32_d     = '0;
      result_32_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      m_q            <= '0;
      sample_idx_q   <= '0;
      period_idx_q   <= '0;
      s1_valid_q     <= 1'b0;
      s1_data_q      <= '0;
      s1_sin_q       <= '0;
      s1_cos_q       <= '0;
      s2_valid_q     <= 1'b0;
      s2_px_q        <= '0;
      s2_py_q        <= '0;
      acc_x_q        <= '0;
      acc_y_q        <= '0;
      result_x_q     <= '0;
      result_y_q     <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      samples_q      <= '0;
`ifdef LOCKIN_RESULT32_EN
      result_x_32_q     <= '0;
      result_y_32_q     <= '0;
      result_32_valid_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      m_q            <= m_d;
      sample_idx_q   <= sample_idx_d;
      period_idx_q   <= period_idx_d;
      s1_valid_q     <= s1_valid_d;
      s1_data_q      <= s1_data_d;
      s1_sin_q       <= s1_sin_d;
      s1_cos_q       <= s1_cos_d;
      s2_valid_q     <= s2_valid_d;
      s2_px_q        <= s2_px_d;
      s2_py_q        <= s2_py_d;
      acc_x_q        <= acc_x_d;
      acc_y_q        <= acc_y_d;
      result_x_q     <= result_x_d;
      result_y_q     <= result_y_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      samples_q      <= samples_d;
`ifdef LOCKIN_RESULT32_EN
      result_x_32_q     <= result_x_32_d;
      result_y_32_q     <= result_y_32_d;
      result_32_valid_q <= result_32_valid_d;
`endif
    end
  end

  assign bus.result_x        = result_x_q;
  assign bus.result_y        = result_y_q;
  assign bus.result_valid    = result_valid_q;
  assign calculo_finalizado  = done_q;
  assign samples_accepted    = samples_q;

endmodule
`default_nettype wire

// File: tb/tb_lockin_accumulator.sv
`default_nettype none
// ============================================================================
// tb_lockin_accumulator : scoreboard bench for lockin_accumulator.
// Revision: 1.0
// ============================================================================
module tb_lockin_accumulator;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        enable;
  logic [15:0] n_samples;
  logic [15:0] n_periods;
  logic        calculo_finalizado;
  logic [31:0] samples_accepted;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    longint x;
    longint y;
    longint cnt;
    longint cyc;
  } exp_t;
  exp_t exp_q[$];

  int pd[4] = '{0, 100, 0, -100};
  int ps[4] = '{0, 1000, 0, -1000};
  int pc[4] = '{1000, 0, -1000, 0};

  lockin_accumulator_if #(.DATA_W(14), .REF_W(16)) bus ();

  lockin_accumulator #(
    .DATA_W(14), .REF_W(16), .CNT_W(16), .SHIFT(4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .clear              (clear),
    .enable             (enable),
    .n_samples          (n_samples),
    .n_periods          (n_periods),
    .bus                (bus.slave),
    .calculo_finalizado (calculo_finalizado),
    .samples_accepted   (samples_accepted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat32_model(input longint v);
    longint s;
    s = v >>> 4;
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  always @(negedge clk) begin
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_x", bus.result_x, e.x);
        check("result_y", bus.result_y, e.y);
        check("samples_accepted", samples_accepted, e.cnt);
        check("pulse_cycle", cyc, e.cyc);
        check("finalizado_rise", calculo_finalizado, 1);
`ifdef LOCKIN_RESULT32_EN
        check("result_32_valid", bus.result_32_valid, 1);
        check("result_x_32", bus.result_x_32, sat32_model(e.x));
        check("result_y_32", bus.result_y_32, sat32_model(e.y));
`endif
      end
    end
  end

  // pat 0: reference test pattern; pat 1: full-scale negative product every sample.
  task automatic do_run(input int n, input int m, input int count,
                        input bit gaps, input bit expect_pulse, input int pat);
    longint ex, ey;
    int d, s, c;
    ex = 0;
    ey = 0;
    bus.sample_valid = 1'b0;
    n_samples = n[15:0];
    n_periods = m[15:0];
    enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        bus.sample_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (pat == 0) begin
        d = pd[i % 4]; s = ps[i % 4]; c = pc[i % 4];
      end else begin
        d = -8192; s = 32767; c = 0;
      end
      bus.sample_data  = d[13:0];
      bus.ref_sin      = s[15:0];
      bus.ref_cos      = c[15:0];
      bus.sample_valid = 1'b1;
      ex += longint'(d) * longint'(s);
      ey += longint'(d) * longint'(c);
      if (expect_pulse && (i == count - 1))
        exp_q.push_back('{ex, ey, longint'(count), longint'(cyc + 4)});
      @(posedge clk); #1;
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      check("pulse_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic finish_run(input longint exp_x);
    repeat (3) @(posedge clk);
    #1;
    check("finalizado_hold", calculo_finalizado, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("finalizado_fall", calculo_finalizado, 0);
    check("result_x_kept", bus.result_x, exp_x);
  endtask

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    enable = 1'b0;
    n_samples = '0;
    n_periods = '0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    bus.ref_sin = '0;
    bus.ref_cos = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result_x", bus.result_x, 0);
    check("rst_result_y", bus.result_y, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_finalizado", calculo_finalizado, 0);
    check("rst_samples", samples_accepted, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero-length period must never start a run.
    n_samples = 16'd0;
    n_periods = 16'd2;
    enable = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_data = 14'd100;
    bus.ref_sin = 16'd1000;
    repeat (20) @(posedge clk);
    #1;
    check("n0_samples", samples_accepted, 0);
    check("n0_finalizado", calculo_finalizado, 0);
    enable = 1'b0;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;

    do_run(4, 2, 8, 1'b0, 1'b1, 0);
    wait_drain(20);
    finish_run(400000);

    do_run(4, 2, 8, 1'b1, 1'b1, 0);
    wait_drain(20);
    finish_run(400000);

    // Abort after 5 samples: no pulse, previous result kept.
    do_run(4, 2, 5, 1'b0, 1'b0, 0);
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_finalizado", calculo_finalizado, 0);
    check("abort_result_kept", bus.result_x, 400000);

    do_run(4, 2, 8, 1'b0, 1'b1, 0);
    wait_drain(20);
    finish_run(400000);

    // Clear lands on the edge that would raise result_valid.
    do_run(4, 2, 8, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    check("clr_result_valid", bus.result_valid, 0);
    check("clr_result_x", bus.result_x, 0);
    check("clr_result_y", bus.result_y, 0);
    check("clr_finalizado", calculo_finalizado, 0);
    check("clr_samples", samples_accepted, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("clr_no_late_pulse", calculo_finalizado, 0);

`ifdef LOCKIN_RESULT32_EN
    do_run(64, 64, 4096, 1'b0, 1'b1, 1);
    wait_drain(20);
    check("x32_saturated", bus.result_x_32, -64'sd2147483648);
    enable = 1'b0;
    @(posedge clk); #1;
    do_run(4, 2, 8, 1'b0, 1'b1, 0);
    wait_drain(20);
    check("x32_scaled", bus.result_x_32, 25000);
    enable = 1'b0;
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
